pll_param_sequencer: RTL and testbench

//  Upstream stage of the DDS PLL reconfiguration path. On a profile request it walks a
//  per-profile table of ALTPLLRECONFIG counter settings (M, N, C0..C4 high/low/bypass/odd)
//  and writes each one with a one-cycle write_param pulse, pacing on busy. It then issues
//  a one-cycle reconfig pulse and reports done, or error on a busy timeout.

---
 rtl/pll_reconfig_pkg.sv | 36 +++
 rtl/pll_profile_rom.sv | 61 ++++++
 rtl/pll_param_sequencer.sv | 106 ++++++++++
 tb/tb_pll_param_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared types for the PLL reconfiguration path: ALTPLLRECONFIG counter and
// parameter codes, the profile ROM entry layout and the sequencer states.
package pll_reconfig_pkg;
  localparam int TYPE_W  = 4;
  localparam int PARAM_W = 3;
  localparam int VAL_W   = 9;

  typedef enum logic [TYPE_W-1:0] {
    CT_N  = 4'd0, CT_M  = 4'd1, CT_CPLF = 4'd2, CT_VCO = 4'd3,
    CT_C0 = 4'd4, CT_C1 = 4'd5, CT_C2   = 4'd6, CT_C3  = 4'd7, CT_C4 = 4'd8
  } ctype_e;

  typedef enum logic [PARAM_W-1:0] {
    CP_HIGH = 3'd0, CP_LOW = 3'd1, CP_BYPASS = 3'd4, CP_ODD = 3'd5
  } cparam_e;

  // 16-bit ROM word: {type[3:0], param[2:0], value[8:0]}
  typedef struct packed {
    logic [TYPE_W-1:0]  ctype;
    logic [PARAM_W-1:0] cparam;
    logic [VAL_W-1:0]   value;
  } entry_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WRITE, S_GUARD, S_WAIT,
    S_RCFG, S_RGUARD, S_RWAIT, S_DONE, S_ERROR
  } state_e;

  function automatic entry_t mk_entry(ctype_e t, cparam_e p, logic [VAL_W-1:0] v);
    entry_t e;
    e.ctype  = t;
    e.cparam = p;
    e.value  = v;
    return e;
  endfunction
endpackage

// File: rtl/pll_profile_rom.sv
// Frequency plans: the counter writes for each profile, in issue order.
// This is the only file that changes when a frequency plan changes.
module pll_profile_rom
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_PROFILES = 4,
  parameter int ENTRIES      = 8,
  localparam int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic [PW-1:0] profile,
  input  logic [IW-1:0] index,
  output entry_t        entry
);
  logic [PW-1:0] prof;

  // Unused profile codes fall back to profile 0.
  if ((1 << PW) == NUM_PROFILES) begin : g_pow2
    assign prof = profile;
  end else begin : g_clip
    assign prof = (32'(profile) < NUM_PROFILES) ? profile : '0;
  end

  always_comb begin
    case (int'({prof, index}))
      0:  entry = mk_entry(CT_N,  CP_HIGH,   9'd1);
      1:  entry = mk_entry(CT_N,  CP_LOW,    9'd1);
      2:  entry = mk_entry(CT_M,  CP_HIGH,   9'd10);
      3:  entry = mk_entry(CT_M,  CP_LOW,    9'd10);
      4:  entry = mk_entry(CT_C0, CP_HIGH,   9'd5);
      5:  entry = mk_entry(CT_C0, CP_LOW,    9'd5);
      6:  entry = mk_entry(CT_C0, CP_ODD,    9'd0);
      7:  entry = mk_entry(CT_C1, CP_BYPASS, 9'd1);
      8:  entry = mk_entry(CT_N,  CP_HIGH,   9'd1);
      9:  entry = mk_entry(CT_N,  CP_LOW,    9'd1);
      10: entry = mk_entry(CT_M,  CP_HIGH,   9'd12);
      11: entry = mk_entry(CT_M,  CP_LOW,    9'd12);
      12: entry = mk_entry(CT_C0, CP_HIGH,   9'd4);
      13: entry = mk_entry(CT_C0, CP_LOW,    9'd4);
      14: entry = mk_entry(CT_C0, CP_ODD,    9'd0);
      15: entry = mk_entry(CT_C1, CP_BYPASS, 9'd1);
      16: entry = mk_entry(CT_N,  CP_HIGH,   9'd2);
      17: entry = mk_entry(CT_N,  CP_LOW,    9'd1);
      18: entry = mk_entry(CT_M,  CP_HIGH,   9'd16);
      19: entry = mk_entry(CT_M,  CP_LOW,    9'd15);
      20: entry = mk_entry(CT_C0, CP_HIGH,   9'd5);
      21: entry = mk_entry(CT_C0, CP_LOW,    9'd4);
      22: entry = mk_entry(CT_C0, CP_ODD,    9'd1);
      23: entry = mk_entry(CT_C1, CP_BYPASS, 9'd0);
      24: entry = mk_entry(CT_N,  CP_HIGH,   9'd1);
      25: entry = mk_entry(CT_N,  CP_LOW,    9'd1);
      26: entry = mk_entry(CT_M,  CP_HIGH,   9'd20);
      27: entry = mk_entry(CT_M,  CP_LOW,    9'd20);
      28: entry = mk_entry(CT_C0, CP_HIGH,   9'd6);
      29: entry = mk_entry(CT_C0, CP_LOW,    9'd6);
      30: entry = mk_entry(CT_C0, CP_ODD,    9'd0);
      31: entry = mk_entry(CT_C1, CP_BYPASS, 9'd1);
      default: entry = '0;
    endcase
  end
endmodule

// File: rtl/pll_param_sequencer.sv
// DDS PLL reconfiguration sequencer: on start, streams one profile's counter
// settings into ALTPLLRECONFIG paced by busy, then fires a reconfig strobe.
module pll_param_sequencer
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_PROFILES = 4,
  parameter int ENTRIES      = 8,
  parameter int DATA_W       = 9,
  parameter int TIMEOUT      = 1023,
  localparam int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PW-1:0]      profile,
  input  logic               busy,
  output logic               write_param,
  output logic               reconfig,
  output logic [TYPE_W-1:0]  counter_type,
  output logic [PARAM_W-1:0] counter_param,
  output logic [DATA_W-1:0]  data_in,
  output logic               active,
  output logic               done,
  output logic               error
);
  state_e        state, state_nxt;
  logic [PW-1:0] prof;
  logic [IW-1:0] index;
  logic [TW-1:0] timer;
  entry_t        rom_entry;
  logic          idle_like, accept, last, waiting, expired;

  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign accept    = idle_like && start;
  assign last      = (index == IW'(ENTRIES - 1));
  assign waiting   = (state == S_WAIT) || (state == S_RWAIT);
  // timer counts busy cycles already spent in this wait; this is the TIMEOUT-th
  assign expired   = busy && (timer == TW'(TIMEOUT - 1));

  pll_profile_rom #(.NUM_PROFILES(NUM_PROFILES), .ENTRIES(ENTRIES)) u_rom (
    .profile (prof),
    .index   (index),
    .entry   (rom_entry)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_WRITE;
      S_WRITE:  state_nxt = S_GUARD;
      S_GUARD:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (!busy)        state_nxt = last ? S_RCFG : S_LOAD;
        else if (expired) state_nxt = S_ERROR;
      end
      S_RCFG:   state_nxt = S_RGUARD;
      S_RGUARD: state_nxt = S_RWAIT;
      S_RWAIT: begin
        if (!busy)        state_nxt = S_DONE;
        else if (expired) state_nxt = S_ERROR;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    write_param = (state == S_WRITE);
    reconfig    = (state == S_RCFG);
    active      = !idle_like;
    done        = (state == S_DONE);
    error       = (state == S_ERROR);
  end

  // Fields are captured once per LOAD so they hold through the busy handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      prof          <= '0;
      index         <= '0;
      timer         <= '0;
      counter_type  <= '0;
      counter_param <= '0;
      data_in       <= '0;
    end else begin
      if (accept) begin
        prof  <= profile;
        index <= '0;
      end else if (state == S_WAIT && !busy && !last) begin
        index <= index + 1'b1;
      end
      timer <= (waiting && busy) ? timer + 1'b1 : '0;
      if (state == S_LOAD) begin
        counter_type  <= rom_entry.ctype;
        counter_param <= rom_entry.cparam;
        data_in       <= DATA_W'(rom_entry.value);
      end
    end
  end
endmodule

// File: tb/tb_pll_param_sequencer.sv
// Bench for pll_param_sequencer: a table of whole sequences plus random busy
// pacing, checked against frequency-plan constants and a strobe timing model.
module tb_pll_param_sequencer;
  localparam int NP = 4, NE = 8, DW = 9, TO = 1023;

  logic          clk = 1'b0;
  logic          reset, start, busy;
  logic [1:0]    profile;
  logic          write_param, reconfig, active, done, error;
  logic [3:0]    counter_type;
  logic [2:0]    counter_param;
  logic [DW-1:0] data_in;

  pll_param_sequencer #(.NUM_PROFILES(NP), .ENTRIES(NE), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .profile       (profile),
    .busy          (busy),
    .write_param   (write_param),
    .reconfig      (reconfig),
    .counter_type  (counter_type),
    .counter_param (counter_param),
    .data_in       (data_in),
    .active        (active),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] prof;
    int         blen;
    int         stall_k;
    int         restart_at;
    int         nwr;
    int         nrc;
    int         edone;
    int         eerr;
    int         eend;
  } vec_t;

  int          n_chk = 0, n_fail = 0, mon_bad = 0;
  logic [15:0] plan [NP][NE];
  vec_t        vecs [6];
  int          blen [NE+1];
  int          ew [NE];
  int          er, ed, quiet;
  int          wr_t[$], rc_t[$];
  logic [15:0] wr_f[$];
  int          end_t, end_done, end_err, timed_out, at1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int gap(input int l);
    return (l + 1 > 2) ? l + 1 : 2;
  endfunction

  // Strobe schedule: a strobe at w with busy high for L cycles afterwards lets
  // the wait exit at w+max(2,L+1); the next write needs LOAD+WRITE, reconfig one cycle.
  task automatic model();
    ew[0] = 2;
    for (int i = 1; i < NE; i++) ew[i] = ew[i-1] + gap(blen[i-1]) + 2;
    er = ew[NE-1] + gap(blen[NE-1]) + 1;
    ed = er + gap(blen[NE]) + 1;
  endtask

  // One sequence, cycle-stepped; busy answers each strobe one cycle later.
  task automatic run(input logic [1:0] prof, input int stall_k, input int restart_at,
                     input int abort_at);
    int t, k, rem, pend;
    wr_t.delete(); wr_f.delete(); rc_t.delete();
    end_t = -1; end_done = 0; end_err = 0; timed_out = 0; at1 = -1;
    k = 0; rem = 0; pend = -1;
    @(posedge clk); #1;
    start = 1'b1; profile = prof; busy = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      if (t == 1) at1 = int'({active, done, error});
      if (write_param) begin
        wr_t.push_back(t);
        wr_f.push_back({counter_type, counter_param, data_in});
      end
      if (reconfig) rc_t.push_back(t);
      if (write_param || reconfig) begin
        pend = (k == stall_k) ? (1 << 30) : ((k <= NE) ? blen[k] : 0);
        k++;
      end
      if ((abort_at >= 0) ? (t == abort_at + 1) : (t > 0 && (done || error))) begin
        end_t = t; end_done = int'(done); end_err = int'(error);
        break;
      end
      if (t >= 3000) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
      t++;
      start = (t == restart_at);
      if (t == restart_at) profile = 2'd1;
      if (t == abort_at) reset = 1'b1;
      if (pend >= 0) begin rem = pend; pend = -1; end
      busy = (rem > 0);
      if (rem > 0) rem--;
    end
    start = 1'b0;
  endtask

  task automatic check_seq(input string tag, input logic [1:0] prof, input int nwr,
                           input int nrc, input int edone, input int eerr, input int eend);
    check({tag, "/timeout"}, timed_out, 0);
    check({tag, "/start_flags"}, at1, 4);
    check({tag, "/n_writes"}, wr_t.size(), nwr);
    for (int i = 0; i < nwr && i < wr_t.size(); i++) begin
      check($sformatf("%s/wr%0d_fields", tag, i), int'(wr_f[i]), int'(plan[prof][i]));
      check($sformatf("%s/wr%0d_cycle", tag, i), wr_t[i], ew[i]);
    end
    check({tag, "/n_reconfig"}, rc_t.size(), nrc);
    if (nrc > 0 && rc_t.size() > 0) check({tag, "/reconfig_cycle"}, rc_t[0], er);
    check({tag, "/done"}, end_done, edone);
    check({tag, "/error"}, end_err, eerr);
    check({tag, "/end_cycle"}, end_t, eend);
    check({tag, "/active_end"}, int'(active), 0);
  endtask

  // Always-on protocol monitor.
  logic        p_wp = 1'b0, p_rc = 1'b0, p_busy = 1'b0;
  logic [15:0] p_f = '0;
  always @(negedge clk) begin
    if (write_param && reconfig) begin
      mon_bad++;
      $display("FAIL strobe_overlap: write_param=1 reconfig=1, expected at most one");
    end
    if (!reset && ((write_param && p_wp) || (reconfig && p_rc))) begin
      mon_bad++;
      $display("FAIL strobe_width: strobe high 2 cycles, expected 1");
    end
    if (!reset && busy && p_busy && {counter_type, counter_param, data_in} != p_f) begin
      mon_bad++;
      $display("FAIL field_stable: fields %h changed from %h while busy",
               {counter_type, counter_param, data_in}, p_f);
    end
    p_wp = write_param; p_rc = reconfig; p_busy = busy;
    p_f = {counter_type, counter_param, data_in};
  end

  initial begin
    plan[0] = '{{4'd0,3'd0,9'd1}, {4'd0,3'd1,9'd1}, {4'd1,3'd0,9'd10}, {4'd1,3'd1,9'd10},
                {4'd4,3'd0,9'd5}, {4'd4,3'd1,9'd5}, {4'd4,3'd5,9'd0},  {4'd5,3'd4,9'd1}};
    plan[1] = '{{4'd0,3'd0,9'd1}, {4'd0,3'd1,9'd1}, {4'd1,3'd0,9'd12}, {4'd1,3'd1,9'd12},
                {4'd4,3'd0,9'd4}, {4'd4,3'd1,9'd4}, {4'd4,3'd5,9'd0},  {4'd5,3'd4,9'd1}};
    plan[2] = '{{4'd0,3'd0,9'd2}, {4'd0,3'd1,9'd1}, {4'd1,3'd0,9'd16}, {4'd1,3'd1,9'd15},
                {4'd4,3'd0,9'd5}, {4'd4,3'd1,9'd4}, {4'd4,3'd5,9'd1},  {4'd5,3'd4,9'd0}};
    plan[3] = '{{4'd0,3'd0,9'd1}, {4'd0,3'd1,9'd1}, {4'd1,3'd0,9'd20}, {4'd1,3'd1,9'd20},
                {4'd4,3'd0,9'd6}, {4'd4,3'd1,9'd6}, {4'd4,3'd5,9'd0},  {4'd5,3'd4,9'd1}};
    //          prof  blen stall restart nwr nrc done err end
    vecs[0] = '{2'd2, 0,   -1,   -1,     8,  1,  1,   0,  36};
    vecs[1] = '{2'd1, 5,   -1,   -1,     8,  1,  1,   0,  72};
    vecs[2] = '{2'd3, 2,   -1,   -1,     8,  1,  1,   0,  45};
    vecs[3] = '{2'd2, 0,   -1,   10,     8,  1,  1,   0,  36};
    vecs[4] = '{2'd0, 0,    2,   -1,     3,  0,  0,   1,  1035};
    vecs[5] = '{2'd0, 1,   -1,   -1,     8,  1,  1,   0,  36};

    reset = 1'b1; start = 1'b0; busy = 1'b0; profile = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({write_param, reconfig, active, done, error,
                                 counter_type, counter_param, data_in}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", int'({write_param, reconfig, active, done, error}), 0);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i <= NE; i++) blen[i] = vecs[n].blen;
      model();
      run(vecs[n].prof, vecs[n].stall_k, vecs[n].restart_at, -1);
      check_seq($sformatf("vec%0d", n), vecs[n].prof, vecs[n].nwr, vecs[n].nrc,
                vecs[n].edone, vecs[n].eerr, vecs[n].eend);
      if (vecs[n].eerr != 0) begin
        quiet = 0;
        repeat (20) begin
          @(negedge clk);
          if (write_param || reconfig) quiet++;
        end
        check("err_no_strobes", quiet, 0);
        check("err_sticky", int'(error), 1);
        @(posedge clk); #1;
        busy = 1'b0;
      end
    end

    // Reset during the 5th WAIT, then a clean sequence from index 0.
    for (int i = 0; i <= NE; i++) blen[i] = 0;
    model();
    run(2'd3, -1, -1, 20);
    check("abort_writes_before", wr_t.size(), 5);
    check("abort_outputs", int'({write_param, reconfig, active, done, error,
                                 counter_type, counter_param, data_in}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run(2'd3, -1, -1, -1);
    check_seq("after_abort", 2'd3, 8, 1, 1, 0, ed);

    for (int n = 0; n < 8; n++) begin
      logic [1:0] p;
      p = 2'($urandom_range(0, NP - 1));
      for (int i = 0; i <= NE; i++) blen[i] = int'($urandom_range(0, 6));
      model();
      run(p, -1, -1, -1);
      check_seq($sformatf("rand%0d", n), p, 8, 1, 1, 0, ed);
    end

    check("protocol_monitor", mon_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
